// File: rtl/oh_demux3_reg_pkg.sv
// Shared constants for the registered 1-to-3 stream demultiplexer.
//   NCH       number of output channels
//   DEST_W    width of the destination select
//   DEST_DROP destination code whose words are accepted and discarded
package oh_demux3_reg_pkg;

  localparam int unsigned NCH = 3;
  localparam int unsigned DEST_W = 2;
  localparam logic [DEST_W-1:0] DEST_DROP = 2'd3;

endpackage

// File: rtl/oh_demux_slot.sv
// One-entry valid/ready output register for a single demux channel.
// Ports:
//   clk, nreset  clock, asynchronous active-low reset
//   push         load data_in this cycle
//   data_in      word to load
//   out_ready    consumer takes the held word this cycle when full
//   full         a word is held (drives the channel valid)
//   data_out     held word, stable while full & ~out_ready
//   slot_ready   slot can take a word this cycle (~full | out_ready)
module oh_demux_slot #(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic          out_ready,
  output logic          full,
  output logic [DW-1:0] data_out,
  output logic          slot_ready
);

  assign slot_ready = ~full | out_ready;

  // Push and pop in the same cycle keep the slot full with the new word.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      full     <= 1'b0;
      data_out <= '0;
    end else begin
      full <= push | (full & ~out_ready);
      if (push) begin
        data_out <= data_in;
      end
    end
  end

endmodule

// File: rtl/oh_demux3_reg.sv
// Registered 1-to-3 stream demultiplexer with per-channel output registers.
// A stalled consumer only blocks words addressed to its own channel.
// Ports:
//   clk, nreset  clock, asynchronous active-low reset
//   in_valid     input word present
//   in_dest      destination 0..2; 3 = drop
//   in_data      input word
//   in_ready     word accepted when in_valid & in_ready
//   out_valid    per-channel word present
//   out_data     channel k data in bits [k*DW +: DW]
//   out_ready    per-channel consumer ready
//   drop_cnt     saturating count of dropped words
//   drop_pulse   one-cycle registered pulse per dropped word
module oh_demux3_reg
  import oh_demux3_reg_pkg::*;
#(
  parameter int unsigned DW = 1,
  parameter int unsigned CW = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              in_valid,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH*DW-1:0] out_data,
  input  logic [NCH-1:0]    out_ready,
  output logic [CW-1:0]     drop_cnt,
  output logic              drop_pulse
);

  logic [NCH-1:0] push;
  logic [NCH-1:0] slot_ready;
  logic           drop;

  // in_ready looks only at the addressed slot; the drop code is always taken.
  always_comb begin
    in_ready = 1'b1;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (in_dest == DEST_W'(k)) begin
        in_ready = slot_ready[k];
      end
    end
  end

  // in_valid gates every state update so X on idle dest/data cannot leak in.
  always_comb begin
    push = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      push[k] = in_valid & slot_ready[k] & (in_dest == DEST_W'(k));
    end
  end

  assign drop = in_valid & (in_dest == DEST_DROP);

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    oh_demux_slot #(
      .DW(DW)
    ) u_slot (
      .clk       (clk),
      .nreset    (nreset),
      .push      (push[k]),
      .data_in   (in_data),
      .out_ready (out_ready[k]),
      .full      (out_valid[k]),
      .data_out  (out_data[k*DW +: DW]),
      .slot_ready(slot_ready[k])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_oh_demux3_reg.sv
// Scoreboard bench for oh_demux3_reg: stimulus pushes expected words per
// channel (and expected drop counts); a negedge monitor pops and compares
// whenever a channel hands off a word or a drop pulse appears.
module tb_oh_demux3_reg;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          nreset;
  logic          in_valid;
  logic [1:0]    in_dest;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [2:0]    out_valid;
  logic [3*DW-1:0] out_data;
  logic [2:0]    out_ready;
  logic [CW-1:0] drop_cnt;
  logic          drop_pulse;

  int n_checks = 0;
  int n_pass = 0;
  int stall_cycles = 0;
  int n_pop2 = 0;
  int drop_model = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int            dq[$];

  always #5 clk = ~clk;

  oh_demux3_reg #(
    .DW(DW),
    .CW(CW)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_dest   (in_dest),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .drop_pulse(drop_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qpop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Drive one word; expected response is queued at the negedge that
  // guarantees acceptance on the following rising edge.
  task automatic send(input logic [1:0] d, input logic [DW-1:0] v);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        case (d)
          2'd0: q0.push_back(v);
          2'd1: q1.push_back(v);
          2'd2: q2.push_back(v);
          default: begin
            if (drop_model != 3) drop_model++;
            dq.push_back(drop_model);
          end
        endcase
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_dest  = 'x;
        in_data  = 'x;
        return;
      end
      stall_cycles++;
    end
    chk("send_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every handed-off word and every drop pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (nreset === 1'b1) begin
        for (int k = 0; k < 3; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            if (qsize(k) == 0) begin
              chk($sformatf("spurious_valid_ch%0d", k), {31'd0, out_valid[k]}, 32'd0);
            end else begin
              chk($sformatf("data_ch%0d", k), {28'd0, out_data[k*DW +: DW]}, {28'd0, qpop(k)});
              if (k == 2) n_pop2++;
            end
          end
        end
        if (drop_pulse) begin
          if (dq.size() == 0) chk("spurious_drop", {31'd0, drop_pulse}, 32'd0);
          else chk("drop_cnt_seq", {30'd0, drop_cnt}, dq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int pop2_base;

    // 1: reset holds outputs idle even with a word offered
    nreset    = 1'b0;
    in_valid  = 1'b1;
    in_dest   = 2'd0;
    in_data   = 4'hF;
    out_ready = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);
    chk("rst_drop_cnt", {30'd0, drop_cnt}, 32'd0);
    chk("rst_out_data", {20'd0, out_data}, 32'd0);
    chk("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #2 nreset = 1'b1;
    idle(2);
    chk("post_rst_empty", {29'd0, out_valid}, 32'd0);

    // 2: routing, one-hot valid one cycle after acceptance
    send(2'd0, 4'hA);
    chk("route_v0", {29'd0, out_valid}, 32'b001);
    chk("route_d0", {28'd0, out_data[3:0]}, 32'hA);
    send(2'd1, 4'hB);
    chk("route_v1", {29'd0, out_valid}, 32'b010);
    chk("route_d1", {28'd0, out_data[7:4]}, 32'hB);
    send(2'd2, 4'hC);
    chk("route_v2", {29'd0, out_valid}, 32'b100);
    chk("route_d2", {28'd0, out_data[11:8]}, 32'hC);
    idle(1);
    chk("route_drained", {29'd0, out_valid}, 32'd0);

    // 3: ch0 stalled, ch1 traffic unaffected
    out_ready = 3'b010;
    send(2'd0, 4'h1);
    in_valid = 1'b1;
    in_dest  = 2'd0;
    in_data  = 4'h2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_data", {28'd0, out_data[3:0]}, 32'h1);
      chk("bp_hold_valid", {31'd0, out_valid[0]}, 32'd1);
    end
    @(posedge clk);
    #1;
    send(2'd1, 4'h5);
    send(2'd1, 4'h6);
    chk("bp_iso_data", {28'd0, out_data[3:0]}, 32'h1);
    chk("bp_iso_valid", {31'd0, out_valid[0]}, 32'd1);
    out_ready = 3'b111;
    send(2'd0, 4'h2);
    chk("bp_next_word", {28'd0, out_data[3:0]}, 32'h2);
    idle(2);

    // 4: one word per cycle into ch2
    out_ready    = 3'b100;
    stall_cycles = 0;
    pop2_base    = n_pop2;
    for (int i = 0; i < 16; i++) begin
      send(2'd2, DW'(i));
      chk("tp_valid", {29'd0, out_valid}, 32'b100);
    end
    idle(2);
    chk("tp_stalls", stall_cycles, 32'd0);
    chk("tp_pops", n_pop2 - pop2_base, 32'd16);

    // 5: drops saturate a 2-bit counter and never touch the channels
    out_ready = 3'b111;
    for (int i = 0; i < 5; i++) begin
      send(2'd3, DW'(i + 8));
      chk("drop_no_valid", {29'd0, out_valid}, 32'd0);
      chk("drop_pulse_hi", {31'd0, drop_pulse}, 32'd1);
    end
    idle(1);
    chk("drop_pulse_lo", {31'd0, drop_pulse}, 32'd0);
    chk("drop_sat", {30'd0, drop_cnt}, 32'd3);

    // 6: async reset with all channels full
    out_ready = 3'b000;
    send(2'd0, 4'h3);
    send(2'd1, 4'h4);
    send(2'd2, 4'h5);
    chk("full_all", {29'd0, out_valid}, 32'b111);
    #3 nreset = 1'b0;
    #1;
    chk("async_rst_valid", {29'd0, out_valid}, 32'd0);
    chk("async_rst_cnt", {30'd0, drop_cnt}, 32'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    drop_model = 0;
    @(posedge clk);
    #2 nreset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 3'b111;
    send(2'd1, 4'h9);
    chk("post_rst_route", {29'd0, out_valid}, 32'b010);
    chk("post_rst_data", {28'd0, out_data[7:4]}, 32'h9);
    idle(2);

    chk("sb_empty", q0.size() + q1.size() + q2.size() + dq.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
